// File: rtl/qpn_alloc_manager_pkg.sv
// Shared definitions for the connection-manager blocks: QPN width, request
// status codes and the allocator FSM state encoding.
package qpn_alloc_manager_pkg;

   localparam int QPN_WIDTH = 24;

   typedef enum logic [1:0] {
      QPN_ST_OK       = 2'd0,
      QPN_ST_NO_FREE  = 2'd1,
      QPN_ST_NOT_OPEN = 2'd2,
      QPN_ST_BAD_QPN  = 2'd3
   } qpn_status_e;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_OPEN_POP    = 3'd1,
      ST_OPEN_RESP   = 3'd2,
      ST_CLOSE_CHECK = 3'd3,
      ST_CLOSE_PUSH  = 3'd4,
      ST_CLOSE_RESP  = 3'd5
   } qpn_state_e;

   // Offset of a QPN inside the local pool; wraps for QPNs below the base.
   function automatic logic [QPN_WIDTH-1:0] qpn_offset(
      input logic [QPN_WIDTH-1:0] qpn,
      input logic [QPN_WIDTH-1:0] base
   );
      return qpn - base;
   endfunction

endpackage

// File: rtl/qpn_alloc_manager_arbiter.sv
// Two-way round-robin grant between QP open and close requests.
// Grants are combinational; the priority pointer flips on every accept.
module qpn_req_arbiter (
   input  logic clk,
   input  logic rst_n,
   input  logic arb_en,
   input  logic open_req,
   input  logic close_req,
   output logic grant_open,
   output logic grant_close
);

   // Low means open was served last, so close wins the first tie.
   logic last_grant_close;

   assign grant_close = arb_en && close_req && (!open_req || !last_grant_close);
   assign grant_open  = arb_en && open_req && (!close_req || last_grant_close);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_close <= 1'b0;
      end else if (grant_open || grant_close) begin
         last_grant_close <= !last_grant_close;
      end
   end

endmodule

// File: rtl/qpn_alloc_manager.sv
// Local QPN allocator: pops QPNs from the free list on open, validates and
// pushes them back on close, and tracks the open set in a bitmap.
//
// state          | meaning
// ---------------+---------------------------------------------------------
// ST_IDLE        | arbitrate open/close requests, latch the granted one
// ST_OPEN_POP    | pool full -> NO_FREE, else wait for and pop a free QPN
// ST_OPEN_RESP   | hold open response until accepted
// ST_CLOSE_CHECK | range and open-bit check, clear the bit on success
// ST_CLOSE_PUSH  | hold free-list push until accepted
// ST_CLOSE_RESP  | hold close response until accepted
module qpn_alloc_manager
   import qpn_alloc_manager_pkg::*;
#(
   parameter int                   MAX_QUEUE_PAIRS = 4,
   parameter logic [QPN_WIDTH-1:0] QPN_BASE        = 24'd256
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 s_open_req_valid,
   output logic                                 s_open_req_ready,
   input  logic [QPN_WIDTH-1:0]                 s_open_req_rem_qpn,
   output logic                                 m_open_resp_valid,
   input  logic                                 m_open_resp_ready,
   output logic [QPN_WIDTH-1:0]                 m_open_resp_loc_qpn,
   output logic [QPN_WIDTH-1:0]                 m_open_resp_rem_qpn,
   output logic [1:0]                           m_open_resp_status,
   input  logic                                 s_close_req_valid,
   output logic                                 s_close_req_ready,
   input  logic [QPN_WIDTH-1:0]                 s_close_req_loc_qpn,
   output logic                                 m_close_resp_valid,
   input  logic                                 m_close_resp_ready,
   output logic [1:0]                           m_close_resp_status,
   input  logic                                 s_free_qpn_valid,
   output logic                                 s_free_qpn_ready,
   input  logic [QPN_WIDTH-1:0]                 s_free_qpn,
   output logic                                 m_free_qpn_valid,
   input  logic                                 m_free_qpn_ready,
   output logic [QPN_WIDTH-1:0]                 m_free_qpn,
   output logic [MAX_QUEUE_PAIRS-1:0]           qp_open_map,
   output logic [$clog2(MAX_QUEUE_PAIRS):0]     open_count,
   output logic                                 err_bad_pop
);

   localparam int                   IDX_W    = $clog2(MAX_QUEUE_PAIRS);
   localparam int                   CNT_W    = IDX_W + 1;
   localparam logic [QPN_WIDTH-1:0] POOL_SZ  = QPN_WIDTH'(MAX_QUEUE_PAIRS);
   localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(MAX_QUEUE_PAIRS);
   localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

   qpn_state_e                 state;
   logic [QPN_WIDTH-1:0]       open_rem_q;
   logic [QPN_WIDTH-1:0]       open_loc_q;
   logic [QPN_WIDTH-1:0]       close_qpn_q;
   qpn_status_e                open_st_q;
   qpn_status_e                close_st_q;
   logic                       open_resp_vld_q;
   logic                       close_resp_vld_q;
   logic                       push_vld_q;
   logic [MAX_QUEUE_PAIRS-1:0] map_q;
   logic [CNT_W-1:0]           cnt_q;
   logic                       err_q;

   logic                       arb_en;
   logic                       grant_open;
   logic                       grant_close;
   logic                       pool_full;
   logic [QPN_WIDTH-1:0]       pop_idx;
   logic                       pop_ok;
   logic [QPN_WIDTH-1:0]       close_idx;
   logic                       close_bad;
   logic                       close_is_open;

   assign arb_en = rst_n && (state == ST_IDLE);

   qpn_req_arbiter u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .arb_en      (arb_en),
      .open_req    (s_open_req_valid),
      .close_req   (s_close_req_valid),
      .grant_open  (grant_open),
      .grant_close (grant_close)
   );

   assign pool_full     = (cnt_q == CNT_FULL);
   assign pop_idx       = qpn_offset(s_free_qpn, QPN_BASE);
   assign pop_ok        = (pop_idx < POOL_SZ) && !map_q[pop_idx[IDX_W-1:0]];
   assign close_idx     = qpn_offset(close_qpn_q, QPN_BASE);
   assign close_bad     = (close_qpn_q < QPN_BASE) || (close_idx >= POOL_SZ);
   assign close_is_open = map_q[close_idx[IDX_W-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         open_rem_q       <= '0;
         open_loc_q       <= '0;
         close_qpn_q      <= '0;
         open_st_q        <= QPN_ST_OK;
         close_st_q       <= QPN_ST_OK;
         open_resp_vld_q  <= 1'b0;
         close_resp_vld_q <= 1'b0;
         push_vld_q       <= 1'b0;
         map_q            <= '0;
         cnt_q            <= '0;
         err_q            <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant_open) begin
                  open_rem_q <= s_open_req_rem_qpn;
                  state      <= ST_OPEN_POP;
               end else if (grant_close) begin
                  close_qpn_q <= s_close_req_loc_qpn;
                  state       <= ST_CLOSE_CHECK;
               end
            end
            ST_OPEN_POP: begin
               if (pool_full) begin
                  open_st_q       <= QPN_ST_NO_FREE;
                  open_loc_q      <= '0;
                  open_resp_vld_q <= 1'b1;
                  state           <= ST_OPEN_RESP;
               end else if (s_free_qpn_valid) begin
                  if (pop_ok) begin
                     map_q[pop_idx[IDX_W-1:0]] <= 1'b1;
                     cnt_q                     <= cnt_q + CNT_ONE;
                     open_loc_q                <= s_free_qpn;
                     open_st_q                 <= QPN_ST_OK;
                  end else begin
                     // Free list handed out a QPN we cannot own: report, keep bitmap.
                     err_q      <= 1'b1;
                     open_loc_q <= '0;
                     open_st_q  <= QPN_ST_NO_FREE;
                  end
                  open_resp_vld_q <= 1'b1;
                  state           <= ST_OPEN_RESP;
               end
            end
            ST_OPEN_RESP: begin
               if (m_open_resp_ready) begin
                  open_resp_vld_q <= 1'b0;
                  state           <= ST_IDLE;
               end
            end
            ST_CLOSE_CHECK: begin
               if (close_bad) begin
                  close_st_q       <= QPN_ST_BAD_QPN;
                  close_resp_vld_q <= 1'b1;
                  state            <= ST_CLOSE_RESP;
               end else if (!close_is_open) begin
                  close_st_q       <= QPN_ST_NOT_OPEN;
                  close_resp_vld_q <= 1'b1;
                  state            <= ST_CLOSE_RESP;
               end else begin
                  map_q[close_idx[IDX_W-1:0]] <= 1'b0;
                  cnt_q                       <= cnt_q - CNT_ONE;
                  close_st_q                  <= QPN_ST_OK;
                  push_vld_q                  <= 1'b1;
                  state                       <= ST_CLOSE_PUSH;
               end
            end
            ST_CLOSE_PUSH: begin
               if (m_free_qpn_ready) begin
                  push_vld_q       <= 1'b0;
                  close_resp_vld_q <= 1'b1;
                  state            <= ST_CLOSE_RESP;
               end
            end
            ST_CLOSE_RESP: begin
               if (m_close_resp_ready) begin
                  close_resp_vld_q <= 1'b0;
                  state            <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs are forced low for the whole reset window, not just after the edge.
   assign s_open_req_ready    = grant_open;
   assign s_close_req_ready   = grant_close;
   assign s_free_qpn_ready    = rst_n && (state == ST_OPEN_POP) && !pool_full && s_free_qpn_valid;
   assign m_open_resp_valid   = rst_n && open_resp_vld_q;
   assign m_open_resp_loc_qpn = rst_n ? open_loc_q : '0;
   assign m_open_resp_rem_qpn = rst_n ? open_rem_q : '0;
   assign m_open_resp_status  = rst_n ? open_st_q : QPN_ST_OK;
   assign m_close_resp_valid  = rst_n && close_resp_vld_q;
   assign m_close_resp_status = rst_n ? close_st_q : QPN_ST_OK;
   assign m_free_qpn_valid    = rst_n && push_vld_q;
   assign m_free_qpn          = rst_n ? close_qpn_q : '0;
   assign qp_open_map         = rst_n ? map_q : '0;
   assign open_count          = rst_n ? cnt_q : '0;
   assign err_bad_pop         = rst_n && err_q;

endmodule

// File: tb/tb_qpn_alloc_manager.sv
// Bench for qpn_alloc_manager: free-list model, response scoreboard, a vector
// table of open/close requests and hand-written reset/backpressure sequences.
module tb_qpn_alloc_manager;
   import qpn_alloc_manager_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_open_req_valid, s_open_req_ready;
   logic [23:0] s_open_req_rem_qpn;
   logic        m_open_resp_valid, m_open_resp_ready;
   logic [23:0] m_open_resp_loc_qpn, m_open_resp_rem_qpn;
   logic [1:0]  m_open_resp_status;
   logic        s_close_req_valid, s_close_req_ready;
   logic [23:0] s_close_req_loc_qpn;
   logic        m_close_resp_valid, m_close_resp_ready;
   logic [1:0]  m_close_resp_status;
   logic        s_free_qpn_valid, s_free_qpn_ready;
   logic [23:0] s_free_qpn;
   logic        m_free_qpn_valid, m_free_qpn_ready;
   logic [23:0] m_free_qpn;
   logic [3:0]  qp_open_map;
   logic [2:0]  open_count;
   logic        err_bad_pop;

   always #5 clk = ~clk;

   qpn_alloc_manager #(.MAX_QUEUE_PAIRS(4), .QPN_BASE(24'd256)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_open_req_valid(s_open_req_valid), .s_open_req_ready(s_open_req_ready),
      .s_open_req_rem_qpn(s_open_req_rem_qpn),
      .m_open_resp_valid(m_open_resp_valid), .m_open_resp_ready(m_open_resp_ready),
      .m_open_resp_loc_qpn(m_open_resp_loc_qpn), .m_open_resp_rem_qpn(m_open_resp_rem_qpn),
      .m_open_resp_status(m_open_resp_status),
      .s_close_req_valid(s_close_req_valid), .s_close_req_ready(s_close_req_ready),
      .s_close_req_loc_qpn(s_close_req_loc_qpn),
      .m_close_resp_valid(m_close_resp_valid), .m_close_resp_ready(m_close_resp_ready),
      .m_close_resp_status(m_close_resp_status),
      .s_free_qpn_valid(s_free_qpn_valid), .s_free_qpn_ready(s_free_qpn_ready),
      .s_free_qpn(s_free_qpn),
      .m_free_qpn_valid(m_free_qpn_valid), .m_free_qpn_ready(m_free_qpn_ready),
      .m_free_qpn(m_free_qpn),
      .qp_open_map(qp_open_map), .open_count(open_count), .err_bad_pop(err_bad_pop)
   );

   wire any_out = s_open_req_ready | m_open_resp_valid | (|m_open_resp_loc_qpn) |
                  (|m_open_resp_rem_qpn) | (|m_open_resp_status) | s_close_req_ready |
                  m_close_resp_valid | (|m_close_resp_status) | s_free_qpn_ready |
                  m_free_qpn_valid | (|m_free_qpn) | (|qp_open_map) | (|open_count) |
                  err_bad_pop;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [23:0] loc;
      logic [23:0] rem;
      logic [1:0]  st;
   } open_exp_t;

   open_exp_t   exp_open[$];
   logic [1:0]  exp_close[$];
   int          acc_order[$];
   logic [23:0] free_q[$];
   int          push_cnt      = 0;
   int          pop_ready_cnt = 0;
   logic [23:0] last_push     = '0;
   int          cyc           = 0;
   int          open_acc_cyc  = 0;
   logic        prev_open_vld = 1'b0;

   // Free-list model and response monitor, both sampling pre-edge values.
   always @(posedge clk) begin
      open_exp_t e;
      logic [1:0] ec;
      cyc++;
      if (s_free_qpn_ready) pop_ready_cnt++;
      if (s_free_qpn_ready && s_free_qpn_valid && free_q.size() > 0) void'(free_q.pop_front());
      if (m_free_qpn_valid && m_free_qpn_ready) begin
         free_q.push_back(m_free_qpn);
         push_cnt++;
         last_push = m_free_qpn;
      end
      if (s_open_req_valid && s_open_req_ready) begin
         acc_order.push_back(0);
         open_acc_cyc = cyc;
      end
      if (s_close_req_valid && s_close_req_ready) acc_order.push_back(1);
      if (m_open_resp_valid && !prev_open_vld) chk("open_latency", cyc - open_acc_cyc, 2);
      prev_open_vld = m_open_resp_valid;
      if (m_open_resp_valid && m_open_resp_ready) begin
         chk("open_resp_expected", 32'(exp_open.size() > 0), 1);
         if (exp_open.size() > 0) begin
            e = exp_open.pop_front();
            chk("open_loc", 32'(m_open_resp_loc_qpn), 32'(e.loc));
            chk("open_rem", 32'(m_open_resp_rem_qpn), 32'(e.rem));
            chk("open_status", 32'(m_open_resp_status), 32'(e.st));
         end
      end
      if (m_close_resp_valid && m_close_resp_ready) begin
         chk("close_resp_expected", 32'(exp_close.size() > 0), 1);
         if (exp_close.size() > 0) begin
            ec = exp_close.pop_front();
            chk("close_status", 32'(m_close_resp_status), 32'(ec));
         end
      end
   end

   always @(negedge clk) begin
      s_free_qpn_valid = (free_q.size() > 0);
      s_free_qpn       = (free_q.size() > 0) ? free_q[0] : 24'd0;
   end

   task automatic open_req(input logic [23:0] rem);
      int n = 0;
      @(negedge clk);
      s_open_req_valid   = 1'b1;
      s_open_req_rem_qpn = rem;
      @(posedge clk);
      while (!s_open_req_ready && n < 200) begin
         n++;
         @(posedge clk);
      end
      chk("open_accepted", 32'(n < 200), 1);
      @(negedge clk);
      s_open_req_valid = 1'b0;
   endtask

   task automatic close_req(input logic [23:0] qpn);
      int n = 0;
      @(negedge clk);
      s_close_req_valid   = 1'b1;
      s_close_req_loc_qpn = qpn;
      @(posedge clk);
      while (!s_close_req_ready && n < 200) begin
         n++;
         @(posedge clk);
      end
      chk("close_accepted", 32'(n < 200), 1);
      @(negedge clk);
      s_close_req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_open.size() > 0 || exp_close.size() > 0) && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("responses_drained", 32'(n < 200), 1);
      @(negedge clk);
   endtask

   task automatic reload_free_list();
      free_q.delete();
      for (int i = 0; i < 4; i++) free_q.push_back(24'(256 + i));
   endtask

   localparam int K_OPEN = 0, K_FULL = 1, K_CLOSE = 2;

   typedef struct {
      int          kind;
      logic [23:0] qpn;
      logic [1:0]  st;
      logic [23:0] loc;
      logic [3:0]  map;
      int          cnt;
      int          npush;
   } vec_t;

   vec_t vecs[12];

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc, pc, n;
      logic [48:0] snap;

      vecs = '{
         '{K_OPEN,  24'h000222, 2'd0, 24'd257, 4'b0011, 2, 0},
         '{K_OPEN,  24'h000333, 2'd0, 24'd258, 4'b0111, 3, 0},
         '{K_OPEN,  24'h000444, 2'd0, 24'd259, 4'b1111, 4, 0},
         '{K_FULL,  24'h000555, 2'd1, 24'd0,   4'b1111, 4, 0},
         '{K_CLOSE, 24'd257,    2'd0, 24'd0,   4'b1101, 3, 1},
         '{K_OPEN,  24'h000666, 2'd0, 24'd257, 4'b1111, 4, 0},
         '{K_CLOSE, 24'd257,    2'd0, 24'd0,   4'b1101, 3, 1},
         '{K_CLOSE, 24'd257,    2'd2, 24'd0,   4'b1101, 3, 0},
         '{K_CLOSE, 24'h000050, 2'd3, 24'd0,   4'b1101, 3, 0},
         '{K_CLOSE, 24'h000104, 2'd3, 24'd0,   4'b1101, 3, 0},
         '{K_CLOSE, 24'd256,    2'd0, 24'd0,   4'b1100, 2, 1},
         '{K_OPEN,  24'h000777, 2'd0, 24'd257, 4'b1110, 3, 0}
      };

      rst_n = 1'b0;
      s_open_req_valid = 1'b0;  s_open_req_rem_qpn  = '0;
      s_close_req_valid = 1'b0; s_close_req_loc_qpn = '0;
      m_open_resp_ready = 1'b1; m_close_resp_ready  = 1'b1;
      m_free_qpn_ready  = 1'b1;
      reload_free_list();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs_zero", 32'(any_out), 0);

      // Simultaneous open and close right after reset: close must be granted first.
      rst_n = 1'b1;
      acc_order.delete();
      exp_close.push_back(2'd2);
      exp_open.push_back(open_exp_t'{24'd256, 24'h000111, 2'd0});
      fork
         open_req(24'h000111);
         close_req(24'd256);
      join
      wait_idle();
      chk("tie_two_grants", 32'(acc_order.size()), 2);
      if (acc_order.size() == 2) begin
         chk("tie_first_close", 32'(acc_order[0]), 1);
         chk("tie_second_open", 32'(acc_order[1]), 0);
      end
      chk("first_open_map", 32'(qp_open_map), 32'h1);
      chk("first_open_count", 32'(open_count), 1);

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].kind == K_CLOSE) begin
            pc = push_cnt;
            exp_close.push_back(vecs[i].st);
            close_req(vecs[i].qpn);
            wait_idle();
            chk("close_push_count", 32'(push_cnt - pc), 32'(vecs[i].npush));
            if (vecs[i].npush != 0) chk("close_push_qpn", 32'(last_push), 32'(vecs[i].qpn));
         end else begin
            if (vecs[i].kind == K_FULL) free_q.push_back(24'h000999);
            rc = pop_ready_cnt;
            exp_open.push_back(open_exp_t'{vecs[i].loc, vecs[i].qpn, vecs[i].st});
            open_req(vecs[i].qpn);
            wait_idle();
            chk("open_pop_count", 32'(pop_ready_cnt - rc), (vecs[i].kind == K_FULL) ? 0 : 1);
            if (vecs[i].kind == K_FULL) begin
               chk("full_freelist_untouched", 32'(free_q.size()), 1);
               free_q.delete();
            end
         end
         chk("vec_map", 32'(qp_open_map), 32'(vecs[i].map));
         chk("vec_count", 32'(open_count), 32'(vecs[i].cnt));
      end
      chk("no_bad_pop_yet", 32'(err_bad_pop), 0);

      // Open response held under 5 cycles of backpressure.
      m_open_resp_ready = 1'b0;
      exp_open.push_back(open_exp_t'{24'd256, 24'h000888, 2'd0});
      open_req(24'h000888);
      n = 0;
      while (!m_open_resp_valid && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("bp_open_valid", 32'(m_open_resp_valid), 1);
      snap = {m_open_resp_valid, m_open_resp_loc_qpn, m_open_resp_rem_qpn};
      repeat (5) begin
         @(negedge clk);
         chk("bp_open_stable", 32'({m_open_resp_valid, m_open_resp_loc_qpn, m_open_resp_rem_qpn} == snap), 1);
         chk("bp_open_status_stable", 32'(m_open_resp_status), 0);
      end
      m_open_resp_ready = 1'b1;
      wait_idle();
      chk("bp_open_map", 32'(qp_open_map), 32'hF);
      chk("bp_open_count", 32'(open_count), 4);

      // Close with both the free-list push and the response backpressured.
      m_free_qpn_ready   = 1'b0;
      m_close_resp_ready = 1'b0;
      pc = push_cnt;
      exp_close.push_back(2'd0);
      close_req(24'd259);
      n = 0;
      while (!m_free_qpn_valid && n < 50) begin
         n++;
         @(negedge clk);
      end
      repeat (3) begin
         chk("bp_push_stable", 32'({m_free_qpn_valid, m_free_qpn}), 32'({1'b1, 24'd259}));
         @(negedge clk);
      end
      m_free_qpn_ready = 1'b1;
      n = 0;
      while (!m_close_resp_valid && n < 50) begin
         n++;
         @(negedge clk);
      end
      repeat (5) begin
         chk("bp_close_stable", 32'({m_close_resp_valid, m_close_resp_status}), 32'({1'b1, 2'd0}));
         @(negedge clk);
      end
      chk("bp_close_single_push", 32'(push_cnt - pc), 1);
      m_close_resp_ready = 1'b1;
      wait_idle();
      chk("bp_close_map", 32'(qp_open_map), 32'h7);
      chk("bp_close_count", 32'(open_count), 3);

      // Free list hands back a QPN that is already open.
      free_q.push_front(24'd256);
      exp_open.push_back(open_exp_t'{24'd0, 24'h000ABC, 2'd1});
      open_req(24'h000ABC);
      wait_idle();
      chk("bad_pop_flag", 32'(err_bad_pop), 1);
      chk("bad_pop_map", 32'(qp_open_map), 32'h7);
      chk("bad_pop_count", 32'(open_count), 3);

      // Reset while a push to the free list is pending.
      m_free_qpn_ready = 1'b0;
      exp_close.push_back(2'd0);
      close_req(24'd257);
      n = 0;
      while (!m_free_qpn_valid && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("rst_push_pending", 32'(m_free_qpn_valid), 1);
      rst_n = 1'b0;
      exp_close.delete();
      free_q.delete();
      #1;
      chk("rst_low_outputs_zero", 32'(any_out), 0);
      @(posedge clk);
      #1;
      chk("rst_after_edge_zero", 32'(any_out), 0);
      chk("rst_map", 32'(qp_open_map), 0);
      chk("rst_count", 32'(open_count), 0);
      reload_free_list();
      @(negedge clk);
      rst_n = 1'b1;
      m_free_qpn_ready = 1'b1;
      exp_open.push_back(open_exp_t'{24'd256, 24'h000123, 2'd0});
      open_req(24'h000123);
      wait_idle();
      chk("post_rst_map", 32'(qp_open_map), 32'h1);
      chk("post_rst_count", 32'(open_count), 1);
      chk("post_rst_err_clear", 32'(err_bad_pop), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
